hazard_scoreboard: RTL
======================

Name: hazard_scoreboard

Overview:
- Parametrised successor to the pipeline hazard control unit.
- Adds a per-register pending-write scoreboard and an outstanding-operation counter, so the core tolerates variable-latency loads and multi-cycle mul/div units that complete out of pipeline order.
- Sits beside decode/execute: gates issue from decode, supplies decode- and execute-stage forwarding selects, and generates fetch/decode stalls and the execute bubble.

Parameters:
- REG_ADDR_W, 5, register address width.
- NUM_REGS, 32, architectural register count (2**REG_ADDR_W).
- MAX_OUTSTANDING, 4, maximum simultaneously in-flight long-latency ops (>=1).
- CNT_W, 3, width of outstanding count; must hold MAX_OUTSTANDING.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- issue_valid_d  in  1  decode holds a valid instruction
- issue_long_d  in  1  decode instruction is long-latency (load/mul/div)
- issue_rd_write_d  in  1  decode instruction writes rd
- issue_rd_d  in  REG_ADDR_W  decode destination
- rs1_d, rs2_d  in  REG_ADDR_W  decode sources
- rs1_used_d, rs2_used_d  in  1  source actually read
- flush_in  in  1  redirect; decode instruction is killed this cycle
- complete_valid  in  1  long op writes back this cycle
- complete_rd  in  REG_ADDR_W  its destination
- rd_write_m, rd_write_w  in  1  memory/writeback stage writes rd
- rd_m, rd_w  in  REG_ADDR_W  their destinations
- rs1_e, rs2_e  in  REG_ADDR_W  execute sources
- mem_valid_f  in  1  instruction fetch data valid
- forwarding_rs1_e, forwarding_rs2_e  out  2  execute bypass select
- forwarding_rs1_d, forwarding_rs2_d  out  1  decode takes completion bus
- stall_f, stall_d  out  1  hold fetch/decode
- flush_e  out  1  insert bubble into execute
- outstanding  out  CNT_W  in-flight long ops
- sb_error  out  1  sticky protocol error
- perf_raw_stalls, perf_struct_stalls  out  32  performance counters

Behaviour:
- Reset (async, rst_n=0): pending[] = 0, outstanding = 0, sb_error = 0, perf counters = 0. Combinational outputs follow inputs with the cleared state.
- Register 0 is never pending and never forwarded; all compares against address 0 are masked.
- raw_hit = any used rsX_d with pending[rsX_d] and NOT (complete_valid && complete_rd == rsX_d).
- waw_hit = issue_long_d && issue_rd_write_d && pending[issue_rd_d]. Completion to the same rd this cycle does not clear waw_hit; it clears next cycle.
- struct_hit = issue_long_d && outstanding == MAX_OUTSTANDING && !complete_valid.
- stall_d = issue_valid_d && (raw_hit || waw_hit || struct_hit).
- stall_f = stall_d || !mem_valid_f.
- flush_e = stall_d.
- accept = issue_valid_d && !stall_d && !flush_in.
- On accept of a long op with rd_write and rd != 0: pending[rd] <= 1 and outstanding increments next edge.
- On complete_valid: pending[complete_rd] <= 0 and outstanding decrements.
  - Simultaneous accept and complete: count unchanged.
  - Same rd in both cannot occur (blocked by waw_hit).
- Completion for a non-pending rd, or with outstanding == 0: sb_error <= 1 (sticky until reset); pending and count are left unchanged; no underflow.
- forwarding_rsX_d = complete_valid && complete_rd == rsX_d && rsX_d != 0. Same-cycle release of a RAW stall relies on this bypass.
- forwarding_rsX_e: 2'b10 if rd_write_m && rd_m == rsX_e != 0; else 2'b01 if rd_write_w && rd_w == rsX_e != 0; else 2'b00. Memory stage has priority.
- flush_in does not clear the scoreboard; ops already issued always complete.
- Latency: scoreboard updates become visible one cycle after accept or complete. All stall and forward outputs are combinational.

Optional Feature:
- Macro: HAZARD_SCOREBOARD_PERF_EN.
- Defined:
  - perf_raw_stalls increments every cycle stall_d is caused by raw_hit or waw_hit.
  - perf_struct_stalls increments on struct_hit-only stall cycles.
  - Both counters saturate at 32'hFFFFFFFF and clear on reset.
- Undefined: both outputs are tied to 0 and no counter flops are synthesised.

Decomposition:
- Package hazard_pkg:
  - forwarding encodings FWD_NONE = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10.
  - stall-cause encoding (NONE/RAW/WAW/STRUCT) for debug.
  - REG_ADDR_W default constant.
- Sub-module hazard_fwd_sel: combinational execute bypass selector for one source, instantiated twice.

Test Plan:
- Reset, then issue long op rd=5 → next cycle pending[5]=1, outstanding=1. Dependent issue with rs1_d=5, rs1_used_d=1 → stall_d=1, flush_e=1, stall_f=1.
- While rd=5 pending, complete_valid with complete_rd=5 → same cycle stall_d=0, forwarding_rs1_d=1. Next cycle outstanding=0.
- MAX_OUTSTANDING=4: issue long ops to rd=1..4, then a long op to rd=6 → stall_d=1. Assert complete_valid rd=1 in the same cycle → stall_d=0, outstanding stays 4.
- rd_write_m=1, rd_m=7, rd_write_w=1, rd_w=7, rs1_e=7 → forwarding_rs1_e=2'b10. Set rs2_e=0 with rd_m=0 → forwarding_rs2_e=2'b00.
- complete_valid rd=9 with nothing pending → sb_error=1 and outstanding stays 0. Assert rst_n=0 mid-stream → all state clears asynchronously.
- With HAZARD_SCOREBOARD_PERF_EN defined: 3 RAW stall cycles plus 2 structural stall cycles → perf_raw_stalls=3, perf_struct_stalls=2.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard scoreboard: forwarding selects, stall causes
// and the default register address width.
package hazard_pkg;

    localparam int REG_ADDR_W_DEF = 5;

    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_WB   = 2'b01,
        FWD_MEM  = 2'b10
    } fwd_sel_e;

    typedef enum logic [1:0] {
        CAUSE_NONE   = 2'b00,
        CAUSE_RAW    = 2'b01,
        CAUSE_WAW    = 2'b10,
        CAUSE_STRUCT = 2'b11
    } stall_cause_e;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Execute-stage bypass selector for one source operand; memory stage wins
// over writeback, and register 0 is never forwarded.
module hazard_fwd_sel
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
    input  logic                  rd_write_m,
    input  logic [REG_ADDR_W-1:0] rd_m,
    input  logic                  rd_write_w,
    input  logic [REG_ADDR_W-1:0] rd_w,
    input  logic [REG_ADDR_W-1:0] rs_e,
    output logic [1:0]            fwd_sel
);

    logic rs_nonzero_s;

    assign rs_nonzero_s = (rs_e != {REG_ADDR_W{1'b0}});

    // Priority select of the youngest producer of rs_e.
    always_comb begin
        fwd_sel = FWD_NONE;
        if (rs_nonzero_s && rd_write_m && (rd_m == rs_e)) begin
            fwd_sel = FWD_MEM;
        end else if (rs_nonzero_s && rd_write_w && (rd_w == rs_e)) begin
            fwd_sel = FWD_WB;
        end else begin
            fwd_sel = FWD_NONE;
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Pending-write scoreboard and hazard control for out-of-order completing
// long-latency ops. Optional perf counters: define HAZARD_SCOREBOARD_PERF_EN.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W      = REG_ADDR_W_DEF,
    parameter int NUM_REGS        = 32,
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_W           = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  issue_valid_d,
    input  logic                  issue_long_d,
    input  logic                  issue_rd_write_d,
    input  logic [REG_ADDR_W-1:0] issue_rd_d,
    input  logic [REG_ADDR_W-1:0] rs1_d,
    input  logic [REG_ADDR_W-1:0] rs2_d,
    input  logic                  rs1_used_d,
    input  logic                  rs2_used_d,
    input  logic                  flush_in,
    input  logic                  complete_valid,
    input  logic [REG_ADDR_W-1:0] complete_rd,
    input  logic                  rd_write_m,
    input  logic                  rd_write_w,
    input  logic [REG_ADDR_W-1:0] rd_m,
    input  logic [REG_ADDR_W-1:0] rd_w,
    input  logic [REG_ADDR_W-1:0] rs1_e,
    input  logic [REG_ADDR_W-1:0] rs2_e,
    input  logic                  mem_valid_f,
    output logic [1:0]            forwarding_rs1_e,
    output logic [1:0]            forwarding_rs2_e,
    output logic                  forwarding_rs1_d,
    output logic                  forwarding_rs2_d,
    output logic                  stall_f,
    output logic                  stall_d,
    output logic                  flush_e,
    output logic [CNT_W-1:0]      outstanding,
    output logic                  sb_error,
    output logic [31:0]           perf_raw_stalls,
    output logic [31:0]           perf_struct_stalls
);

    localparam logic [REG_ADDR_W-1:0] ADDR_ZERO = {REG_ADDR_W{1'b0}};
    localparam logic [CNT_W-1:0]      CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]      CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]      CNT_MAX   = CNT_W'(MAX_OUTSTANDING);

    logic [NUM_REGS-1:0] pending_r;
    logic [NUM_REGS-1:0] pending_nxt_s;
    logic [CNT_W-1:0]    outstanding_r;
    logic [CNT_W-1:0]    outstanding_nxt_s;
    logic                sb_error_r;

    logic rs1_fwd_s, rs2_fwd_s;
    logic raw_hit_s, waw_hit_s, struct_hit_s;
    logic stall_d_s, accept_s, alloc_s, complete_ok_s, complete_bad_s;

    // Hazard detection; a same-cycle completion releases RAW through the bypass.
    always_comb begin
        rs1_fwd_s      = complete_valid && (complete_rd == rs1_d) && (rs1_d != ADDR_ZERO);
        rs2_fwd_s      = complete_valid && (complete_rd == rs2_d) && (rs2_d != ADDR_ZERO);
        raw_hit_s      = (rs1_used_d && (rs1_d != ADDR_ZERO) && pending_r[rs1_d] && !rs1_fwd_s) ||
                         (rs2_used_d && (rs2_d != ADDR_ZERO) && pending_r[rs2_d] && !rs2_fwd_s);
        waw_hit_s      = issue_long_d && issue_rd_write_d && (issue_rd_d != ADDR_ZERO) &&
                         pending_r[issue_rd_d];
        struct_hit_s   = issue_long_d && (outstanding_r == CNT_MAX) && !complete_valid;
        stall_d_s      = issue_valid_d && (raw_hit_s || waw_hit_s || struct_hit_s);
        accept_s       = issue_valid_d && !stall_d_s && !flush_in;
        alloc_s        = accept_s && issue_long_d && issue_rd_write_d && (issue_rd_d != ADDR_ZERO);
        complete_ok_s  = complete_valid && (complete_rd != ADDR_ZERO) && pending_r[complete_rd] &&
                         (outstanding_r != CNT_ZERO);
        complete_bad_s = complete_valid && !complete_ok_s;
    end

    // Next scoreboard contents; a bad completion leaves state untouched.
    always_comb begin
        pending_nxt_s = pending_r;
        if (complete_ok_s) begin
            pending_nxt_s[complete_rd] = 1'b0;
        end else begin
            pending_nxt_s[complete_rd] = pending_r[complete_rd];
        end
        if (alloc_s) begin
            pending_nxt_s[issue_rd_d] = 1'b1;
        end else begin
            pending_nxt_s[issue_rd_d] = pending_nxt_s[issue_rd_d];
        end
        case ({alloc_s, complete_ok_s})
            2'b10:   outstanding_nxt_s = outstanding_r + CNT_ONE;
            2'b01:   outstanding_nxt_s = outstanding_r - CNT_ONE;
            default: outstanding_nxt_s = outstanding_r;
        endcase
    end

    // Scoreboard state, outstanding count and sticky protocol error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_r     <= {NUM_REGS{1'b0}};
            outstanding_r <= CNT_ZERO;
            sb_error_r    <= 1'b0;
        end else begin
            pending_r     <= pending_nxt_s;
            outstanding_r <= outstanding_nxt_s;
            sb_error_r    <= sb_error_r || complete_bad_s;
        end
    end

    hazard_fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_rs1 (
        .rd_write_m (rd_write_m),
        .rd_m       (rd_m),
        .rd_write_w (rd_write_w),
        .rd_w       (rd_w),
        .rs_e       (rs1_e),
        .fwd_sel    (forwarding_rs1_e)
    );

    hazard_fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_rs2 (
        .rd_write_m (rd_write_m),
        .rd_m       (rd_m),
        .rd_write_w (rd_write_w),
        .rd_w       (rd_w),
        .rs_e       (rs2_e),
        .fwd_sel    (forwarding_rs2_e)
    );

    assign forwarding_rs1_d = rs1_fwd_s;
    assign forwarding_rs2_d = rs2_fwd_s;
    assign stall_d          = stall_d_s;
    assign stall_f          = stall_d_s || !mem_valid_f;
    assign flush_e          = stall_d_s;
    assign outstanding      = outstanding_r;
    assign sb_error         = sb_error_r;

`ifdef HAZARD_SCOREBOARD_PERF_EN
    logic [31:0]  perf_raw_r;
    logic [31:0]  perf_struct_r;
    stall_cause_e cause_s;

    // Dominant stall cause; structural only counts when no data hazard exists.
    always_comb begin
        cause_s = CAUSE_NONE;
        if (!stall_d_s) begin
            cause_s = CAUSE_NONE;
        end else if (raw_hit_s) begin
            cause_s = CAUSE_RAW;
        end else if (waw_hit_s) begin
            cause_s = CAUSE_WAW;
        end else begin
            cause_s = CAUSE_STRUCT;
        end
    end

    // Saturating stall counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_raw_r    <= 32'h0000_0000;
            perf_struct_r <= 32'h0000_0000;
        end else begin
            if (((cause_s == CAUSE_RAW) || (cause_s == CAUSE_WAW)) && (perf_raw_r != 32'hFFFF_FFFF)) begin
                perf_raw_r <= perf_raw_r + 32'h0000_0001;
            end
            if ((cause_s == CAUSE_STRUCT) && (perf_struct_r != 32'hFFFF_FFFF)) begin
                perf_struct_r <= perf_struct_r + 32'h0000_0001;
            end
        end
    end

    assign perf_raw_stalls    = perf_raw_r;
    assign perf_struct_stalls = perf_struct_r;
`else
    assign perf_raw_stalls    = 32'h0000_0000;
    assign perf_struct_stalls = 32'h0000_0000;
`endif

endmodule
